icache_ctrl: RTL and testbench

Direct-mapped instruction cache sitting directly downstream of the program counter stage, between PC and the instruction memory.
- Consumes PC each cycle and returns INSTRUCTION.
- On a miss, raises BUSYWAIT so the PC stage and register file freeze, fetches a 16-byte block from instruction memory via a busy-wait handshake, then serves the hit.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_if.sv | 23 ++
 rtl/icache_array.sv | 43 ++++
 rtl/icache_ctrl.sv | 92 +++++++++
 tb/tb_icache_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and PC field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned OFF_W   = 2;
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned NBLK    = 1 << IDX_W;
  localparam int unsigned BADDR_W = IDX_W + TAG_W;

  typedef enum logic {
    IDLE,
    MEM_READ
  } state_t;

  function automatic logic [OFF_W-1:0] get_offset(input logic [31:0] pc);
    return pc[2 +: OFF_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_index(input logic [31:0] pc);
    return pc[2 + OFF_W +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] pc);
    return pc[2 + OFF_W + IDX_W +: TAG_W];
  endfunction

endpackage

// File: rtl/icache_if.sv
// Block-read bus between the instruction cache (master) and instruction memory (slave).
interface icache_if;

  logic                                MEM_READ;
  logic [icache_pkg::BADDR_W-1:0]      MEM_ADDRESS;
  logic [icache_pkg::BLK_W-1:0]        MEM_READDATA;
  logic                                MEM_BUSYWAIT;

  modport master (
    output MEM_READ,
    output MEM_ADDRESS,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT
  );

  modport slave (
    input  MEM_READ,
    input  MEM_ADDRESS,
    output MEM_READDATA,
    output MEM_BUSYWAIT
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: synchronous block fill, combinational lookup and word select.
module icache_array
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   rd_index,
  input  logic [TAG_W-1:0]   rd_tag,
  input  logic [OFF_W-1:0]   rd_offset,
  output logic               hit,
  output logic [31:0]        rd_word,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLK_W-1:0]   wr_data
);

  logic [NBLK-1:0]  valid;
  logic [TAG_W-1:0] tag_array  [NBLK];
  logic [BLK_W-1:0] data_array [NBLK];

  // Only the valid bits are cleared; tag/data stay undefined until first fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_array[wr_index]  <= wr_tag;
      data_array[wr_index] <= wr_data;
    end
  end

  always_comb begin
    hit     = valid[rd_index] && (tag_array[rd_index] == rd_tag);
    rd_word = data_array[rd_index][{rd_offset, 5'b00000} +: 32];
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hits, busy-wait block fill on miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        BUSYWAIT,
  icache_if.master    MEM
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] HIT_COUNT,
  output logic [31:0] MISS_COUNT
`endif
);

  state_t             state;
  logic               mem_read_r;
  logic [BADDR_W-1:0] miss_addr;
  logic               hit;
  logic               fill_en;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^{PC[31:BADDR_W+OFF_W+2], PC[1:0]};

  icache_array u_array (
    .CLK       (CLK),
    .RESET     (RESET),
    .rd_index  (get_index(PC)),
    .rd_tag    (get_tag(PC)),
    .rd_offset (get_offset(PC)),
    .hit       (hit),
    .rd_word   (INSTRUCTION),
    .wr_en     (fill_en),
    .wr_index  (miss_addr[IDX_W-1:0]),
    .wr_tag    (miss_addr[BADDR_W-1:IDX_W]),
    .wr_data   (MEM.MEM_READDATA)
  );

  // Fill targets the captured block, never the live PC; reset suppresses it.
  assign fill_en         = (state == MEM_READ) && !MEM.MEM_BUSYWAIT && !RESET;
  assign BUSYWAIT        = (state == MEM_READ) || !hit;
  assign MEM.MEM_READ    = mem_read_r;
  assign MEM.MEM_ADDRESS = miss_addr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      mem_read_r <= 1'b0;
      miss_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state      <= MEM_READ;
            mem_read_r <= 1'b1;
            miss_addr  <= {get_tag(PC), get_index(PC)};
          end
        end
        MEM_READ: begin
          if (!MEM.MEM_BUSYWAIT) begin
            state      <= IDLE;
            mem_read_r <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          mem_read_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else if (state == IDLE) begin
      if (hit && (HIT_COUNT != '1)) begin
        HIT_COUNT <= HIT_COUNT + 32'd1;
      end
      if (!hit && (MISS_COUNT != '1)) begin
        MISS_COUNT <= MISS_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios then random fetches against a block-address cache model.
module tb_icache_ctrl;

  logic        CLK;
  logic        RESET;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic        BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [31:0] HIT_COUNT;
  logic [31:0] MISS_COUNT;
`endif

  icache_if mem_bus ();

  icache_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .PC          (PC),
    .INSTRUCTION (INSTRUCTION),
    .BUSYWAIT    (BUSYWAIT),
    .MEM         (mem_bus)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT   (HIT_COUNT),
    .MISS_COUNT  (MISS_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory image, one 128-bit block per 16-byte block address.
  logic [127:0] mem_img [64];
  int           lat;
  int           busy_cnt;

  // Memory: holds busywait for 'lat' cycles of a request, then presents the block.
  always @(negedge CLK) begin
    if (mem_bus.MEM_READ === 1'b1) begin
      if (busy_cnt < lat) begin
        busy_cnt = busy_cnt + 1;
        mem_bus.MEM_BUSYWAIT = 1'b1;
        mem_bus.MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        mem_bus.MEM_BUSYWAIT = 1'b0;
        mem_bus.MEM_READDATA = mem_img[mem_bus.MEM_ADDRESS];
      end
    end else begin
      busy_cnt = 0;
      mem_bus.MEM_BUSYWAIT = 1'b0;
    end
  end

  // Model: which block address each slot holds, plus an outstanding-miss flag.
  bit          m_valid [8];
  logic [5:0]  m_blk   [8];
  bit          m_fill;
  logic [5:0]  m_cap;
  logic [31:0] m_hits;
  logic [31:0] m_miss;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    logic [5:0] b;
    b = pc[9:4];
    return m_valid[b[2:0]] && (m_blk[b[2:0]] == b);
  endfunction

  task automatic step(input logic [31:0] pc, input logic rst, output bit busy);
    logic [127:0] blk;
    logic [5:0]   b;
    @(negedge CLK);
    PC    = pc;
    RESET = rst;
    #2;
    b    = pc[9:4];
    busy = m_fill || !m_hit(pc);
    chk("busywait", 32'(BUSYWAIT), 32'(busy));
    chk("mem_read", 32'(mem_bus.MEM_READ), 32'(m_fill));
    chk("mem_addr", 32'(mem_bus.MEM_ADDRESS), 32'(m_cap));
    if (!busy) begin
      blk = mem_img[b];
      chk("instruction", INSTRUCTION, blk[{pc[3:2], 5'b00000} +: 32]);
    end
`ifdef ICACHE_STATS_EN
    chk("hit_count", HIT_COUNT, m_hits);
    chk("miss_count", MISS_COUNT, m_miss);
`endif
    if (rst) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_fill = 1'b0;
      m_cap  = '0;
      m_hits = '0;
      m_miss = '0;
    end else if (m_fill) begin
      if (!mem_bus.MEM_BUSYWAIT) begin
        m_valid[m_cap[2:0]] = 1'b1;
        m_blk[m_cap[2:0]]   = m_cap;
        m_fill              = 1'b0;
      end
    end else if (m_hit(pc)) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
    end else begin
      m_fill = 1'b1;
      m_cap  = b;
      if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    bit busy;
    int n;
    n = 0;
    do begin
      step(pc, 1'b0, busy);
      n++;
    end while (busy && n < 60);
    total++;
    assert (!busy) else begin
      bad++;
      $error("FAIL fetch_timeout pc=%h got=busy exp=ready", pc);
    end
  endtask

  initial begin
    bit          busy;
    logic [31:0] rpc;
    total    = 0;
    bad      = 0;
    lat      = 5;
    busy_cnt = 0;
    m_fill   = 1'b0;
    m_cap    = '0;
    m_hits   = '0;
    m_miss   = '0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_blk[i]   = '0;
    end
    for (int i = 0; i < 64; i++) mem_img[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_img[0] = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    mem_bus.MEM_BUSYWAIT = 1'b0;
    mem_bus.MEM_READDATA = '0;
    RESET = 1'b1;
    PC    = '0;
    @(posedge CLK);

    // Reset state, then first fetch misses with a 5-cycle memory
    step(32'h0, 1'b1, busy);
    step(32'h0, 1'b1, busy);
    fetch(32'h000);
    fetch(32'h004);
    fetch(32'h008);
    fetch(32'h00C);

    // Conflict on index 0, then eviction back
    lat = 2;
    fetch(32'h080);
    fetch(32'h000);
    fetch(32'h080);

    // Reset during the fill: returned data must not be written
    lat = 1;
    step(32'h0, 1'b0, busy);
    step(32'h0, 1'b0, busy);
    step(32'h0, 1'b1, busy);
    step(32'h0, 1'b0, busy);
    fetch(32'h000);

    // Single-cycle memory
    lat = 0;
    fetch(32'h1C4);
    fetch(32'h1C8);
    fetch(32'h3F0);

    // Random fetches, including PC moving mid-miss, ignored PC bits and rare resets
    busy = 1'b0;
    rpc  = '0;
    for (int i = 0; i < 500; i++) begin
      if (!busy || $urandom_range(0, 7) == 0) begin
        rpc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) |
              ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) rpc = rpc | ($urandom & 32'hFFFF_FC00);
      end
      if (!busy) lat = $urandom_range(0, 4);
      step(rpc, ($urandom_range(0, 59) == 0), busy);
    end
    fetch(32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
